llsc_reservation_monitor: RTL and testbench

//   Memory-side responder for the LL/SC pair issued by the openMIPS MEM stage.

---
 rtl/llsc_reservation_monitor_if.sv | 35 +++
 rtl/llsc_reservation_monitor.sv | 121 ++++++++++++
 tb/tb_llsc_reservation_monitor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/llsc_reservation_monitor_if.sv
// rtl/llsc_reservation_monitor_if.sv - MEM-stage / snoop / data_ram bundle for the LL/SC reservation monitor
interface llsc_reservation_monitor_if;
    logic        req_ce_i;
    logic        req_we_i;
    logic        req_ll_i;
    logic        req_sc_i;
    logic [31:0] req_addr_i;
    logic [3:0]  req_sel_i;
    logic [31:0] req_data_i;
    logic        snp_we_i;
    logic [31:0] snp_addr_i;
    logic        flush_i;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_o;
    logic        sc_result_o;
    logic        llbit_o;
    logic [29:0] link_addr_o;

    modport master (
        output req_ce_i, req_we_i, req_ll_i, req_sc_i, req_addr_i, req_sel_i, req_data_i,
        output snp_we_i, snp_addr_i, flush_i,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
        input  sc_result_o, llbit_o, link_addr_o
    );

    modport slave (
        input  req_ce_i, req_we_i, req_ll_i, req_sc_i, req_addr_i, req_sel_i, req_data_i,
        input  snp_we_i, snp_addr_i, flush_i,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
        output sc_result_o, llbit_o, link_addr_o
    );
endinterface

// File: rtl/llsc_reservation_monitor.sv
// rtl/llsc_reservation_monitor.sv - word-granular LL/SC reservation monitor; optional timeout via LLSC_TIMEOUT_EN
module llsc_reservation_monitor #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    llsc_reservation_monitor_if.slave    bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LINKED = 1'b1
    } state_t;

    // Parameter sanity: lifetime must be at least 2 and the last count must fit the counter.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_param
        $error("llsc_reservation_monitor: TIMEOUT_CYCLES out of range for CNT_W");
    end

    state_t      state_q, state_d;
    logic [29:0] link_addr_q, link_addr_d;

    logic [29:0] req_word;
    logic [29:0] snp_word;
    logic        linked;
    logic        is_ll;
    logic        is_sc;
    logic        store_hit;
    logic        snoop_conflict;
    logic        sc_pass;
    logic        timeout_hit;
    logic        unused_snp_lsb;

    assign req_word       = bus.req_addr_i[31:2];
    assign snp_word       = bus.snp_addr_i[31:2];
    assign unused_snp_lsb = ^bus.snp_addr_i[1:0];
    assign linked         = (state_q == LINKED);
    assign is_ll          = bus.req_ce_i & bus.req_ll_i;
    assign is_sc          = bus.req_ce_i & bus.req_sc_i;
    assign store_hit      = bus.req_ce_i & bus.req_we_i & ~bus.req_sc_i & linked & (req_word == link_addr_q);

    // A snoop kills the existing link, and also an LL to the same word issued in the same cycle.
    assign snoop_conflict = bus.snp_we_i & ((linked & (snp_word == link_addr_q)) | (is_ll & (snp_word == req_word)));

`ifdef LLSC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout_hit = linked & (cnt_q == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // SC decision is same-cycle; a same-word snoop racing the SC makes it fail.
    assign sc_pass = is_sc & linked & (req_word == link_addr_q) & ~bus.flush_i
                     & ~(bus.snp_we_i & (snp_word == link_addr_q));

    // data_ram side: pass-through when the access is valid, failing SC loses its write enable.
    always_comb begin
        bus.ram_ce_o    = bus.req_ce_i;
        bus.ram_we_o    = bus.req_ce_i & bus.req_we_i & (~bus.req_sc_i | sc_pass);
        bus.ram_addr_o  = bus.req_ce_i ? bus.req_addr_i : 32'h0;
        bus.ram_sel_o   = bus.req_ce_i ? bus.req_sel_i  : 4'h0;
        bus.ram_data_o  = bus.req_ce_i ? bus.req_data_i : 32'h0;
        bus.sc_result_o = sc_pass;
        bus.llbit_o     = linked;
        bus.link_addr_o = link_addr_q;
    end

    // Next-state: flush > snoop conflict > SC > conflicting store > LL > timeout.
    always_comb begin
        state_d     = state_q;
        link_addr_d = link_addr_q;
`ifdef LLSC_TIMEOUT_EN
        cnt_d = cnt_q;
        if (linked && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
`endif
        if (bus.flush_i) begin
            state_d = IDLE;
        end else if (snoop_conflict) begin
            state_d = IDLE;
        end else if (is_sc) begin
            state_d = IDLE;
        end else if (store_hit) begin
            state_d = IDLE;
        end else if (is_ll) begin
            state_d     = LINKED;
            link_addr_d = req_word;
`ifdef LLSC_TIMEOUT_EN
            cnt_d = '0;
`endif
        end else if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    // Reservation registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            link_addr_q <= 30'h0;
        end else begin
            state_q     <= state_d;
            link_addr_q <= link_addr_d;
        end
    end

`ifdef LLSC_TIMEOUT_EN
    // Reservation age counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_llsc_reservation_monitor.sv
// tb/tb_llsc_reservation_monitor.sv - directed and random checks of the LL/SC reservation monitor
module tb_llsc_reservation_monitor;

    localparam int TB_TIMEOUT = 4;
    localparam int OP_NOP = 0;
    localparam int OP_LW  = 1;
    localparam int OP_SW  = 2;
    localparam int OP_LL  = 3;
    localparam int OP_SC  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    llsc_reservation_monitor_if bus ();

    llsc_reservation_monitor #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .CNT_W          (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Small data_ram stand-in fed by the monitor's RAM port.
    logic [31:0] ram [0:15];
    always @(posedge clk) begin
        if (bus.ram_ce_o && bus.ram_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_sel_o[b]) ram[bus.ram_addr_o[5:2]][8*b +: 8] <= bus.ram_data_o[8*b +: 8];
            end
        end
    end

    // Reference reservation: one flag, one word number and an age in cycles.
    bit          ref_linked = 0;
    int unsigned ref_word   = 0;
    int          ref_age    = 0;
    logic        last_sc;
    logic        last_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int op, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                        input bit snp, input logic [31:0] snp_addr, input bit flush);
        bit ce, we, ll, sc, exp_pass, exp_we;
        int unsigned rw, sw;
        ce = (op != OP_NOP);
        we = (op == OP_SW) || (op == OP_SC);
        ll = (op == OP_LL);
        sc = (op == OP_SC);
        bus.req_ce_i   = ce;
        bus.req_we_i   = we;
        bus.req_ll_i   = ll;
        bus.req_sc_i   = sc;
        bus.req_addr_i = addr;
        bus.req_sel_i  = sel;
        bus.req_data_i = data;
        bus.snp_we_i   = snp;
        bus.snp_addr_i = snp_addr;
        bus.flush_i    = flush;
        rw = addr >> 2;
        sw = snp_addr >> 2;
        @(negedge clk);
        exp_pass = sc && ref_linked && (rw == ref_word) && !flush && !(snp && sw == ref_word);
        exp_we   = we && (!sc || exp_pass);
        last_sc  = bus.sc_result_o;
        last_we  = bus.ram_we_o;
        check("sc_result", {31'h0, bus.sc_result_o}, {31'h0, exp_pass});
        check("ram_we", {31'h0, bus.ram_we_o}, {31'h0, exp_we});
        check("ram_ce", {31'h0, bus.ram_ce_o}, {31'h0, ce});
        check("ram_addr", bus.ram_addr_o, ce ? addr : 32'h0);
        check("ram_data", bus.ram_data_o, ce ? data : 32'h0);
        check("ram_sel", {28'h0, bus.ram_sel_o}, ce ? {28'h0, sel} : 32'h0);
        check("llbit", {31'h0, bus.llbit_o}, {31'h0, ref_linked});
        if (ref_linked) check("link_addr", {2'b00, bus.link_addr_o}, ref_word);
        @(posedge clk);
        if (flush) ref_linked = 0;
        else if (snp && ((ref_linked && sw == ref_word) || (ll && sw == rw))) ref_linked = 0;
        else if (sc) ref_linked = 0;
        else if (op == OP_SW && ref_linked && rw == ref_word) ref_linked = 0;
        else if (ll) begin
            ref_linked = 1;
            ref_word   = rw;
            ref_age    = 0;
        end else if (ref_linked) begin
`ifdef LLSC_TIMEOUT_EN
            if (ref_age == TB_TIMEOUT - 1) ref_linked = 0;
`endif
            ref_age++;
        end
        #1;
    endtask

    task automatic op(input int o, input logic [31:0] addr, input logic [31:0] data);
        step(o, addr, data, 4'hF, 0, 32'h0, 0);
    endtask

    initial begin
        bus.req_ce_i = 0; bus.req_we_i = 0; bus.req_ll_i = 0; bus.req_sc_i = 0;
        bus.req_addr_i = 0; bus.req_sel_i = 0; bus.req_data_i = 0;
        bus.snp_we_i = 0; bus.snp_addr_i = 0; bus.flush_i = 0;
        #12;
        check("rst_llbit", {31'h0, bus.llbit_o}, 32'h0);
        check("rst_link_addr", {2'b00, bus.link_addr_o}, 32'h0);
        check("rst_sc_result", {31'h0, bus.sc_result_o}, 32'h0);
        check("rst_ram_ce", {31'h0, bus.ram_ce_o}, 32'h0);
        @(posedge clk); #1;
        rst = 0;

        op(OP_SW, 32'h0, 32'h1234);
        // SC without LL
        op(OP_SC, 32'h0, 32'h5678);
        check("t2_sc", {31'h0, last_sc}, 32'h0);
        check("t2_we", {31'h0, last_we}, 32'h0);
        check("t2_mem", ram[0], 32'h1234);
        // LL then SC to the same word
        op(OP_LL, 32'h0, 32'h0);
        op(OP_SC, 32'h0, 32'h1235);
        check("t1_sc", {31'h0, last_sc}, 32'h1);
        check("t1_we", {31'h0, last_we}, 32'h1);
        check("t1_mem", ram[0], 32'h1235);
        check("t1_llbit", {31'h0, bus.llbit_o}, 32'h0);
        // same-word snoop between LL and SC
        op(OP_LL, 32'h4, 32'h0);
        step(OP_NOP, 32'h0, 32'h0, 4'h0, 1, 32'h6, 0);
        op(OP_SC, 32'h4, 32'h9);
        check("t3_sc", {31'h0, last_sc}, 32'h0);
        check("t3_we", {31'h0, last_we}, 32'h0);
        // different-word snoop
        op(OP_LL, 32'h4, 32'h0);
        step(OP_NOP, 32'h0, 32'h0, 4'h0, 1, 32'h8, 0);
        op(OP_SC, 32'h4, 32'h9);
        check("t3b_sc", {31'h0, last_sc}, 32'h1);
        // flushed LL never links
        step(OP_LL, 32'h0, 32'h0, 4'hF, 0, 32'h0, 1);
        check("t4_llbit", {31'h0, bus.llbit_o}, 32'h0);
        // flush pulse clears the link
        op(OP_LL, 32'h0, 32'h0);
        step(OP_NOP, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1);
        op(OP_SC, 32'h0, 32'h1);
        check("t4b_sc", {31'h0, last_sc}, 32'h0);
        // LL racing a same-word snoop
        step(OP_LL, 32'h0, 32'h0, 4'hF, 1, 32'h0, 0);
        check("t4c_llbit", {31'h0, bus.llbit_o}, 32'h0);
        // ordinary store to the linked word
        op(OP_LL, 32'h8, 32'h0);
        op(OP_SW, 32'h8, 32'h0);
        op(OP_SC, 32'h8, 32'h7);
        check("t5_sc", {31'h0, last_sc}, 32'h0);
        // SC to another word
        op(OP_LL, 32'h8, 32'h0);
        op(OP_SC, 32'hC, 32'h7);
        check("t5b_sc", {31'h0, last_sc}, 32'h0);
        check("t5b_llbit", {31'h0, bus.llbit_o}, 32'h0);
        // asynchronous reset while linked
        op(OP_LL, 32'h0, 32'h0);
        check("t6c_linked", {31'h0, bus.llbit_o}, 32'h1);
        rst = 1;
        #1;
        check("t6c_llbit", {31'h0, bus.llbit_o}, 32'h0);
        ref_linked = 0;
        @(posedge clk); #1;
        rst = 0;
        op(OP_SC, 32'h0, 32'h3);
        check("t6c_sc", {31'h0, last_sc}, 32'h0);
        check("t6c_we", {31'h0, last_we}, 32'h0);
`ifdef LLSC_TIMEOUT_EN
        // reservation expires after TIMEOUT_CYCLES idle cycles
        op(OP_LL, 32'h0, 32'h0);
        for (int i = 0; i < TB_TIMEOUT; i++) op(OP_NOP, 32'h0, 32'h0);
        check("t6_llbit", {31'h0, bus.llbit_o}, 32'h0);
        op(OP_SC, 32'h0, 32'h1);
        check("t6_sc", {31'h0, last_sc}, 32'h0);
        // SC in the final cycle still passes
        op(OP_LL, 32'h0, 32'h0);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) op(OP_NOP, 32'h0, 32'h0);
        op(OP_SC, 32'h0, 32'h1);
        check("t6b_sc", {31'h0, last_sc}, 32'h1);
`endif
        // random traffic over four words with random byte offsets
        for (int i = 0; i < 400; i++) begin
            int o;
            o = $urandom_range(0, 9);
            o = (o >= 5) ? ((o >= 8) ? OP_LL : OP_SC) : o;
            step(o, {26'h0, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))}, $urandom, 4'($urandom),
                 ($urandom_range(0, 3) == 0), {26'h0, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
                 ($urandom_range(0, 9) == 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
